// File: rtl/apb_rr_master_if.sv
// rtl/apb_rr_master_if.sv - APB bus bundle shared by the round-robin master and its slave
interface apb_rr_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - two-requester round-robin APB master with wait-state timeout
module apb_rr_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [1:0]          req_write_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    apb_rr_master_if.master     apb
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q;
    logic                psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [CNT_W-1:0]    wait_q;

    logic                winner_d;
    logic                timeout_hit_d;

    // On contention the requester that did not win last time goes next.
    assign winner_d      = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
    assign timeout_hit_d = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && req_valid_i != 2'b00)
            req_ready_o = winner_d ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wait_q       <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req_valid_i != 2'b00) begin
                        paddr_q      <= winner_d ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
                        pwdata_q     <= winner_d ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
                        pwrite_q     <= req_write_i[winner_d];
                        owner_q      <= winner_d;
                        last_grant_q <= winner_d;
                        psel_q       <= 1'b1;
                        penable_q    <= 1'b0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready || timeout_hit_d) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        // pslverr only counts in the pready cycle; a timeout always errors.
                        rsp_err_q   <= apb.pready ? apb.pslverr : 1'b1;
                        rsp_rdata_q <= (apb.pready && !pwrite_q) ? apb.prdata : '0;
                    end else if (TIMEOUT != 0) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - directed scoreboard bench for apb_rr_master
module tb_apb_rr_master;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    apb_rr_master_if #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_rr_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input int owner, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.vld   = (owner == 1) ? 2'b10 : 2'b01;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Advance one clock, land 1ns after the edge and score any response pulse.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.vld});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    endtask

    task automatic drive(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[idx]         = 1'b1;
        req_write[idx]         = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = wdata;
    endtask

    task automatic check_phase(input string tag, input logic sel, input logic en);
        check({tag, "_psel"}, {63'd0, apb.psel}, {63'd0, sel});
        check({tag, "_penable"}, {63'd0, apb.penable}, {63'd0, en});
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        apb.prdata = '0; apb.pready = 1'b1; apb.pslverr = 1'b0;
        cyc(); cyc();

        // reset state
        check("rst_psel", {63'd0, apb.psel}, 64'd0);
        check("rst_penable", {63'd0, apb.penable}, 64'd0);
        check("rst_pwrite", {63'd0, apb.pwrite}, 64'd0);
        check("rst_paddr", {32'd0, apb.paddr}, 64'd0);
        check("rst_pwdata", {32'd0, apb.pwdata}, 64'd0);
        check("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        check("rst_ready", {62'd0, req_ready}, 64'd0);
        rst = 1'b0;
        cyc();

        // 1: single write, requester 0, zero wait states
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        check("t1_ready", {62'd0, req_ready}, 64'd1);
        expect_rsp(0, 32'h0, 1'b0);
        cyc();
        req_valid = 2'b00;
        check_phase("t1_setup", 1'b1, 1'b0);
        cyc();
        check_phase("t1_access", 1'b1, 1'b1);
        check("t1_paddr", {32'd0, apb.paddr}, 64'h10);
        check("t1_pwdata", {32'd0, apb.pwdata}, 64'hDEADBEEF);
        check("t1_pwrite", {63'd0, apb.pwrite}, 64'd1);
        cyc();
        check("t1_rsp_at_t3", {62'd0, rsp_valid}, 64'd1);
        check_phase("t1_idle", 1'b0, 1'b0);
        check("t1_paddr_kept", {32'd0, apb.paddr}, 64'h10);

        // 2: read with 3 wait states on requester 1; pslverr during waits is ignored
        drive(1, 1'b0, 32'h20, 32'h0);
        apb.pready = 1'b0; apb.pslverr = 1'b1;
        #1;
        check("t2_ready", {62'd0, req_ready}, 64'd2);
        expect_rsp(1, 32'h12345678, 1'b0);
        cyc();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_phase("t2_access", 1'b1, 1'b1);
            check("t2_paddr", {32'd0, apb.paddr}, 64'h20);
        end
        // fourth ACCESS cycle: complete now
        apb.pready = 1'b1; apb.pslverr = 1'b0; apb.prdata = 32'h12345678;
        cyc();
        check("t2_rsp", {62'd0, rsp_valid}, 64'd2);

        // 3: contention from reset, grants alternate 0,1,0,1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(0, 1'b1, 32'h100, 32'hA0);
        drive(1, 1'b0, 32'h200, 32'h0);
        apb.prdata = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_grant", {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k % 2 == 0) expect_rsp(0, 32'h0, 1'b0);
            else            expect_rsp(1, 32'hCAFE0001, 1'b0);
            cyc(); cyc();
            check("t3_paddr", {32'd0, apb.paddr}, (k % 2 == 0) ? 64'h100 : 64'h200);
            cyc();
        end
        req_valid = 2'b00;
        #1;
        check("t3_sb_drained", 64'(sb.size()), 64'd0);

        // 4A: slave error on a read with pready=1
        drive(0, 1'b0, 32'h30, 32'h0);
        apb.pslverr = 1'b1; apb.prdata = 32'h55AA;
        #1;
        check("t4a_ready", {62'd0, req_ready}, 64'd1);
        expect_rsp(0, 32'h55AA, 1'b1);
        cyc();
        req_valid = 2'b00;
        cyc(); cyc();
        apb.pslverr = 1'b0;

        // 4B: timeout after 4 ACCESS cycles, read data forced to 0
        drive(1, 1'b0, 32'h40, 32'h0);
        apb.pready = 1'b0; apb.prdata = 32'hFFFFFFFF;
        #1;
        expect_rsp(1, 32'h0, 1'b1);
        cyc();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_phase("t4b_access", 1'b1, 1'b1);
        end
        cyc();
        check("t4b_rsp", {62'd0, rsp_valid}, 64'd2);
        check_phase("t4b_after", 1'b0, 1'b0);

        // 5: reset mid-ACCESS; aborted transfer never responds, requester 0 wins next
        drive(0, 1'b0, 32'h50, 32'h0);
        #1;
        cyc();
        req_valid = 2'b00;
        cyc(); cyc();
        check_phase("t5_pre", 1'b1, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_phase("t5_post", 1'b0, 1'b0);
        check("t5_no_rsp", {62'd0, rsp_valid}, 64'd0);
        apb.pready = 1'b1; apb.prdata = 32'h0BADF00D;
        drive(0, 1'b0, 32'h54, 32'h0);
        drive(1, 1'b0, 32'h58, 32'h0);
        #1;
        check("t5_first_grant", {62'd0, req_ready}, 64'd1);
        expect_rsp(0, 32'h0BADF00D, 1'b0);
        cyc();
        req_valid[0] = 1'b0;
        cyc(); cyc();
        #1;
        check("t5_second_grant", {62'd0, req_ready}, 64'd2);
        expect_rsp(1, 32'h0BADF00D, 1'b0);
        cyc();
        req_valid = 2'b00;
        cyc(); cyc();

        // 6: back-to-back on requester 0, accept in the response cycle
        drive(0, 1'b1, 32'h60, 32'h11111111);
        #1;
        check("t6_ready1", {62'd0, req_ready}, 64'd1);
        expect_rsp(0, 32'h0, 1'b0);
        cyc();
        drive(0, 1'b1, 32'h64, 32'h22222222);
        cyc(); cyc();
        check("t6_rsp", {62'd0, rsp_valid}, 64'd1);
        check("t6_ready2", {62'd0, req_ready}, 64'd1);
        expect_rsp(0, 32'h0, 1'b0);
        cyc();
        req_valid = 2'b00;
        check_phase("t6_setup2", 1'b1, 1'b0);
        check("t6_paddr2", {32'd0, apb.paddr}, 64'h64);
        cyc(); cyc();
        cyc();

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
